// File: rtl/divider_16by8.sv
// Sequential unsigned restoring divider (2*BIT / BIT), valid/ready on both sides, dbz/ovf flags.
// Optional macro DIVIDER_RADIX4_EN: two restoring steps per CALC cycle instead of one.
module divider_16by8 #(
  parameter int BIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*BIT-1:0] dividend,
  input  logic [BIT-1:0]   divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIT-1:0]   quotient,
  output logic [BIT-1:0]   remainder,
  output logic             dbz,
  output logic             ovf
);

`ifdef DIVIDER_RADIX4_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam int CW = $clog2(BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT / STEPS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [BIT-1:0]  r_q, r_d;
  logic [BIT-1:0]  sh_q, sh_d;
  logic [BIT-1:0]  dvs_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q, out_valid_q, dbz_q, ovf_q;
  logic [BIT-1:0]  quotient_q, remainder_q;

  // R < divisor on entry, so the difference is exact in BIT bits; the compare needs the carry-out bit.
  function automatic logic [BIT:0] div_step(input logic [BIT-1:0] r, input logic b,
                                            input logic [BIT-1:0] d);
    logic [BIT:0] t;
    t = {r, b};
    if (t >= {1'b0, d}) return {1'b1, t[BIT-1:0] - d};
    else                return {1'b0, t[BIT-1:0]};
  endfunction

  logic           qb1;
  logic [BIT-1:0] r1;
`ifdef DIVIDER_RADIX4_EN
  logic           qb2;
  logic [BIT-1:0] r2;
`endif

  // Dividend bits leave sh at the MSB while quotient bits enter at the LSB.
  always_comb begin
    {qb1, r1} = div_step(r_q, sh_q[BIT-1], dvs_q);
`ifdef DIVIDER_RADIX4_EN
    {qb2, r2} = div_step(r1, sh_q[BIT-2], dvs_q);
    r_d  = r2;
    sh_d = {sh_q[BIT-3:0], qb1, qb2};
`else
    r_d  = r1;
    sh_d = {sh_q[BIT-2:0], qb1};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      r_q         <= '0;
      sh_q        <= '0;
      dvs_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            dvs_q      <= divisor;
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend[BIT-1:0];
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (dividend[2*BIT-1:BIT] >= divisor) begin
              quotient_q  <= '1;
              remainder_q <= dividend[BIT-1:0];
              dbz_q       <= 1'b0;
              ovf_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              r_q     <= dividend[2*BIT-1:BIT];
              sh_q    <= dividend[BIT-1:0];
              cnt_q   <= '0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            quotient_q  <= sh_d;
            remainder_q <= r_d;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_divider_16by8.sv
// Directed self-checking bench for divider_16by8 (radix-2 default, DIVIDER_RADIX4_EN aware).
module tb_divider_16by8;

`ifdef DIVIDER_RADIX4_EN
  localparam int CALC_LAT = 4;
`else
  localparam int CALC_LAT = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        dbz;
  logic        ovf;

  int tests_run = 0;
  int failures  = 0;

  divider_16by8 #(.BIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Issue one operation and return the number of rising edges from accept until out_valid (-1 if never).
  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv, output int lat);
    int w;
    lat = -1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, out_valid, dbz, ovf} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags: got rdy/vld/dbz/ovf=%b want 1000", {in_ready, out_valid, dbz, ovf});
    end
    tests_run++;
    if ({quotient, remainder} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data: got q=%h r=%h want 00/00", quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_normal();
    int lat;
    run_op(16'hFE01, 8'hFF, lat);
    tests_run++;
    if (lat !== CALC_LAT) begin
      failures++;
      $display("FAIL normal_latency: got %0d want %0d", lat, CALC_LAT);
    end
    tests_run++;
    if ({quotient, remainder, dbz, ovf, in_ready} !== {8'hFF, 8'h00, 3'b000}) begin
      failures++;
      $display("FAIL normal_fe01_ff: got q=%h r=%h dbz=%b ovf=%b rdy=%b want FF 00 0 0 0",
               quotient, remainder, dbz, ovf, in_ready);
    end
    consume();
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL normal_release: got vld/rdy=%b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_basic();
    int lat;
    run_op(16'h03E8, 8'h07, lat);
    tests_run++;
    if ({quotient, remainder, dbz, ovf} !== {8'h8E, 8'h06, 2'b00} || lat !== CALC_LAT) begin
      failures++;
      $display("FAIL basic_03e8_07: got q=%h r=%h dbz=%b ovf=%b lat=%0d want 8E 06 0 0 %0d",
               quotient, remainder, dbz, ovf, lat, CALC_LAT);
    end
    consume();
  endtask

  task automatic test_dbz();
    int lat;
    run_op(16'h1234, 8'h00, lat);
    tests_run++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL dbz_latency: got %0d want 1", lat);
    end
    tests_run++;
    if ({quotient, remainder, dbz, ovf} !== {8'hFF, 8'h34, 2'b10}) begin
      failures++;
      $display("FAIL dbz_result: got q=%h r=%h dbz=%b ovf=%b want FF 34 1 0", quotient, remainder, dbz, ovf);
    end
    consume();
  endtask

  task automatic test_ovf();
    int lat;
    run_op(16'h0800, 8'h08, lat);
    tests_run++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL ovf_latency: got %0d want 1", lat);
    end
    tests_run++;
    if ({quotient, remainder, dbz, ovf} !== {8'hFF, 8'h00, 2'b01}) begin
      failures++;
      $display("FAIL ovf_result: got q=%h r=%h dbz=%b ovf=%b want FF 00 0 1", quotient, remainder, dbz, ovf);
    end
    consume();
  endtask

  // dividend = a*b + r with r < b always has dividend[15:8] < b, so it must take the normal path.
  task automatic test_roundtrip();
    int a_list[4] = '{0, 1, 100, 255};
    int b_list[5] = '{1, 3, 17, 128, 255};
    int lat;
    int r;
    logic [15:0] dd;
    for (int bi = 0; bi < 5; bi++) begin
      for (int ai = 0; ai < 4; ai++) begin
        for (int k = 0; k < 2; k++) begin
          r  = (k == 0) ? 0 : b_list[bi] - 1;
          dd = 16'(a_list[ai] * b_list[bi] + r);
          run_op(dd, 8'(b_list[bi]), lat);
          tests_run++;
          if ({quotient, remainder, dbz, ovf} !== {8'(a_list[ai]), 8'(r), 2'b00} || lat !== CALC_LAT) begin
            failures++;
            $display("FAIL roundtrip_%h_%h: got q=%h r=%h dbz=%b ovf=%b lat=%0d want %h %h 0 0 %0d",
                     dd, 8'(b_list[bi]), quotient, remainder, dbz, ovf, lat,
                     8'(a_list[ai]), 8'(r), CALC_LAT);
          end
          consume();
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(16'h03E8, 8'h07, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      dividend = 16'h0064;
      divisor  = 8'h0A;
      in_valid = 1'b1;
      tests_run++;
      if ({out_valid, in_ready, quotient, remainder} !== {2'b10, 8'h8E, 8'h06}) begin
        failures++;
        $display("FAIL backpressure_hold_%0d: got vld=%b rdy=%b q=%h r=%h want 1 0 8E 06",
                 c, out_valid, in_ready, quotient, remainder);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, quotient, remainder} !== {2'b01, 8'h8E, 8'h06}) begin
      failures++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b q=%h r=%h want 0 1 8E 06",
               out_valid, in_ready, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    run_op(16'h0064, 8'h0A, lat);
    tests_run++;
    if ({quotient, remainder} !== {8'h0A, 8'h00} || lat !== CALC_LAT || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got q=%h r=%h lat=%0d rdy=%b want 0A 00 %0d 0", quotient, remainder, lat, in_ready, CALC_LAT);
    end
    run_op(16'hFE01, 8'hFF, lat);
    tests_run++;
    if ({quotient, remainder} !== {8'hFF, 8'h00} || lat !== CALC_LAT) begin
      failures++;
      $display("FAIL b2b_second: got q=%h r=%h lat=%0d want FF 00 %0d", quotient, remainder, lat, CALC_LAT);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_drain: got vld/rdy=%b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    @(negedge clk);
    dividend = 16'h03E8;
    divisor  = 8'h07;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, in_ready, dbz, ovf, quotient, remainder} !== {4'b0100, 16'h0000}) begin
      failures++;
      $display("FAIL abort_outputs: got vld=%b rdy=%b dbz=%b ovf=%b q=%h r=%h want 0 1 0 0 00 00",
               out_valid, in_ready, dbz, ovf, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_result: got %0d cycles of out_valid want 0", seen);
    end
    run_op(16'h0064, 8'h0A, lat);
    tests_run++;
    if ({quotient, remainder, dbz, ovf} !== {8'h0A, 8'h00, 2'b00} || lat !== CALC_LAT) begin
      failures++;
      $display("FAIL abort_next_op: got q=%h r=%h dbz=%b ovf=%b lat=%0d want 0A 00 0 0 %0d",
               quotient, remainder, dbz, ovf, lat, CALC_LAT);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_basic();
    test_dbz();
    test_ovf();
    test_roundtrip();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule
